// File: rtl/pn_i2s_rx.sv
// I2S master receiver: generates the codec bit clock and word select, captures stereo
// ADC samples and presents each frame as one AXI-Stream word, counting overrun drops.
module pn_i2s_rx #(
    parameter int CLK_DIV = 128
) (
    input  logic        ax_clk,
    input  logic        ax_rst,
    output logic        rx_Bclk,
    output logic        rx_LRCIN,
    input  logic        rx_DIN,
    output logic [31:0] rx_ax_m_data,
    output logic        rx_ax_m_valid,
    input  logic        rx_ax_m_ready,
    output logic [7:0]  rx_ovf_cnt
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    // Two cycles after the bit-clock rise, so the synchronizer output holds the pin value seen at the rise.
    localparam logic [DW-1:0] DIV_CAP  = DW'(CLK_DIV / 2 + 2);

    logic [DW-1:0] r_div_cnt;
    logic [4:0]    r_bit_cnt;
    logic          r_bclk;
    logic          r_lrcin;
    logic          r_din_s1;
    logic          r_din_s2;
    logic [31:0]   r_shift;
    logic          r_primed;
    logic          r_word_rdy;
    logic [31:0]   r_data;
    logic          r_valid;
    logic [7:0]    r_ovf_cnt;

    logic          w_div_wrap;
    logic [DW-1:0] w_div_nxt;
    logic [4:0]    w_bit_nxt;
    logic          w_capture;
    logic          w_complete;
    logic          w_xfer;
    logic [31:0]   w_word;

    always_comb begin
        w_div_nxt  = {DW{1'b0}};
        w_bit_nxt  = r_bit_cnt;
        w_div_wrap = (r_div_cnt == DIV_LAST);
        if (w_div_wrap) begin
            w_div_nxt = {DW{1'b0}};
            w_bit_nxt = r_bit_cnt + 5'd1;
        end else begin
            w_div_nxt = r_div_cnt + DIV_ONE;
            w_bit_nxt = r_bit_cnt;
        end
        w_capture  = (w_div_nxt == DIV_CAP);
        // Slot 0 carries the right LSB, the last bit of a frame that started at slot 1.
        w_complete = w_capture && r_primed && (r_bit_cnt == 5'd0);
        w_xfer     = r_valid && rx_ax_m_ready;
        // Left arrives first, so it sits in the upper half of the shift register.
        w_word     = {r_shift[15:0], r_shift[31:16]};
    end

    always_ff @(posedge ax_clk) begin
        if (ax_rst) begin
            r_div_cnt <= {DW{1'b0}};
            r_bit_cnt <= 5'd0;
            r_bclk    <= 1'b0;
            r_lrcin   <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_bclk    <= (w_div_nxt >= DIV_HALF);
            r_lrcin   <= w_bit_nxt[4];
        end
    end

    always_ff @(posedge ax_clk) begin
        if (ax_rst) begin
            r_din_s1   <= 1'b0;
            r_din_s2   <= 1'b0;
            r_shift    <= 32'd0;
            r_primed   <= 1'b0;
            r_word_rdy <= 1'b0;
        end else begin
            r_din_s1   <= rx_DIN;
            r_din_s2   <= r_din_s1;
            r_word_rdy <= w_complete;
            if (w_capture) begin
                r_shift <= {r_shift[30:0], r_din_s2};
                if (r_bit_cnt == 5'd1) begin
                    r_primed <= 1'b1;
                end
            end
        end
    end

    // The word is taken from the shift register one edge after completion; no capture can intervene.
    always_ff @(posedge ax_clk) begin
        if (ax_rst) begin
            r_data    <= 32'd0;
            r_valid   <= 1'b0;
            r_ovf_cnt <= 8'd0;
        end else if (r_word_rdy) begin
            if (!r_valid || w_xfer) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else if (r_ovf_cnt != 8'hFF) begin
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    assign rx_Bclk       = r_bclk;
    assign rx_LRCIN      = r_lrcin;
    assign rx_ax_m_data  = r_data;
    assign rx_ax_m_valid = r_valid;
    assign rx_ovf_cnt    = r_ovf_cnt;

endmodule

// File: tb/tb_pn_i2s_rx.sv
// Directed bench for pn_i2s_rx: a slot-tracking codec model feeds the default-divider
// instance; a small-divider instance runs stalled alongside to reach overrun saturation.
module tb_pn_i2s_rx;

    logic        ax_clk = 1'b0;
    logic        ax_rst;
    logic        rx_Bclk;
    logic        rx_LRCIN;
    logic        rx_DIN;
    logic [31:0] rx_ax_m_data;
    logic        rx_ax_m_valid;
    logic        rx_ax_m_ready;
    logic [7:0]  rx_ovf_cnt;

    logic        sat_rst;
    logic        sat_bclk;
    logic        sat_lrcin;
    logic [31:0] sat_data;
    logic        sat_valid;
    logic        sat_ready;
    logic [7:0]  sat_ovf;

    int          tests_run = 0;
    int          tests_failed = 0;
    int unsigned cyc = 0;
    int unsigned sat_rel = 0;

    logic [15:0] tx_left, tx_right, cur_l, cur_r;
    bit          auto_inc;
    int          slot;
    logic        prev_b, prev_lr;

    pn_i2s_rx #(.CLK_DIV(128)) dut (
        .ax_clk(ax_clk), .ax_rst(ax_rst), .rx_Bclk(rx_Bclk), .rx_LRCIN(rx_LRCIN),
        .rx_DIN(rx_DIN), .rx_ax_m_data(rx_ax_m_data), .rx_ax_m_valid(rx_ax_m_valid),
        .rx_ax_m_ready(rx_ax_m_ready), .rx_ovf_cnt(rx_ovf_cnt)
    );

    pn_i2s_rx #(.CLK_DIV(8)) dut_sat (
        .ax_clk(ax_clk), .ax_rst(sat_rst), .rx_Bclk(sat_bclk), .rx_LRCIN(sat_lrcin),
        .rx_DIN(rx_DIN), .rx_ax_m_data(sat_data), .rx_ax_m_valid(sat_valid),
        .rx_ax_m_ready(sat_ready), .rx_ovf_cnt(sat_ovf)
    );

    always #5 ax_clk = ~ax_clk;

    always @(posedge ax_clk) cyc <= cyc + 1;

    function automatic logic codec_bit(input int s, input logic [15:0] l, input logic [15:0] r);
        if (s >= 1 && s <= 16) return l[16 - s];
        else if (s >= 17) return r[32 - s];
        else return r[0];
    endfunction

    // Codec slave: counts bit-clock falls, realigns on the word-select fall, new sample pair at slot 1.
    initial begin
        rx_DIN = 1'b0; slot = 0; prev_b = 1'b0; prev_lr = 1'b0; cur_l = 16'h0; cur_r = 16'h0;
        forever begin
            @(posedge ax_clk);
            #1;
            if (ax_rst === 1'b1) begin
                slot = 0;
                rx_DIN = 1'b0;
            end else if (prev_b === 1'b1 && rx_Bclk === 1'b0) begin
                if (prev_lr === 1'b1 && rx_LRCIN === 1'b0) slot = 0;
                else slot = (slot + 1) % 32;
                if (slot == 1) begin
                    cur_l = tx_left;
                    cur_r = tx_right;
                    if (auto_inc) begin
                        tx_left  = tx_left + 16'd1;
                        tx_right = tx_right + 16'd1;
                    end
                end
                rx_DIN = codec_bit(slot, cur_l, cur_r);
            end
            prev_b  = rx_Bclk;
            prev_lr = rx_LRCIN;
        end
    end

    task automatic do_reset(input logic [15:0] l, input logic [15:0] r, input bit inc);
        @(negedge ax_clk);
        ax_rst = 1'b1;
        tx_left = l; tx_right = r; auto_inc = inc;
        repeat (3) @(negedge ax_clk);
        ax_rst = 1'b0;
    endtask

    task automatic test_reset;
        repeat (4) @(negedge ax_clk);
        tests_run++; if (rx_Bclk !== 1'b0) begin tests_failed++; $display("FAIL rst_bclk: got %b expected 0", rx_Bclk); end
        tests_run++; if (rx_LRCIN !== 1'b0) begin tests_failed++; $display("FAIL rst_lrcin: got %b expected 0", rx_LRCIN); end
        tests_run++; if (rx_ax_m_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b expected 0", rx_ax_m_valid); end
        tests_run++; if (rx_ax_m_data !== 32'h0) begin tests_failed++; $display("FAIL rst_data: got %h expected 00000000", rx_ax_m_data); end
        tests_run++; if (rx_ovf_cnt !== 8'h0) begin tests_failed++; $display("FAIL rst_ovf: got %0d expected 0", rx_ovf_cnt); end
        ax_rst = 1'b0;
        sat_rst = 1'b0;
        sat_rel = cyc;
    endtask

    task automatic test_clocks;
        int first_rise = -1, last_edge = 0, bclk_bad = 0, bclk_edges = 0;
        int lr_rise = -1, lr_fall = -1, lr_bad = 0;
        logic pb = 1'b0, pl = 1'b0;
        for (int n = 1; n <= 4200; n++) begin
            @(negedge ax_clk);
            if (rx_Bclk !== pb) begin
                bclk_edges++;
                if (first_rise < 0) first_rise = n;
                else if (n - last_edge != 64) bclk_bad++;
                last_edge = n;
            end
            if (rx_LRCIN !== pl) begin
                if (!(pb === 1'b1 && rx_Bclk === 1'b0)) lr_bad++;
                if (rx_LRCIN === 1'b1 && lr_rise < 0) lr_rise = n;
                if (rx_LRCIN === 1'b0 && lr_fall < 0) lr_fall = n;
            end
            pb = rx_Bclk;
            pl = rx_LRCIN;
        end
        tests_run++; if (first_rise != 64) begin tests_failed++; $display("FAIL bclk_first_rise: got %0d expected 64", first_rise); end
        tests_run++; if (bclk_bad != 0 || bclk_edges != 65) begin tests_failed++; $display("FAIL bclk_period: got %0d bad half-periods over %0d edges expected 0 over 65", bclk_bad, bclk_edges); end
        tests_run++; if (lr_rise != 2048) begin tests_failed++; $display("FAIL lrcin_rise: got %0d expected 2048", lr_rise); end
        tests_run++; if (lr_fall != 4096) begin tests_failed++; $display("FAIL lrcin_fall: got %0d expected 4096", lr_fall); end
        tests_run++; if (lr_bad != 0) begin tests_failed++; $display("FAIL lrcin_on_bclk_fall: got %0d stray toggles expected 0", lr_bad); end
    endtask

    task automatic test_single_frame;
        int first = -1, nvalid = 0;
        logic [31:0] got = 32'h0;
        rx_ax_m_ready = 1'b1;
        do_reset(16'h8001, 16'h7FFE, 1'b0);
        for (int n = 1; n <= 4300; n++) begin
            @(negedge ax_clk);
            if (rx_ax_m_valid === 1'b1) begin
                nvalid++;
                if (first < 0) begin first = n; got = rx_ax_m_data; end
            end
        end
        tests_run++; if (first != 4163) begin tests_failed++; $display("FAIL single_latency: got %0d expected 4163", first); end
        tests_run++; if (got !== 32'h7FFE8001) begin tests_failed++; $display("FAIL single_data: got %h expected 7ffe8001", got); end
        tests_run++; if (nvalid != 1) begin tests_failed++; $display("FAIL single_pulse: got %0d valid cycles expected 1", nvalid); end
    endtask

    task automatic test_priming;
        int first = -1, early = 0;
        logic [31:0] got = 32'h0;
        rx_ax_m_ready = 1'b1;
        @(negedge ax_clk);
        tx_left = 16'hFFFF; tx_right = 16'hFFFF;
        repeat (2500) @(negedge ax_clk);
        do_reset(16'h1234, 16'hFEDC, 1'b0);
        for (int n = 1; n <= 4300; n++) begin
            @(negedge ax_clk);
            if (rx_ax_m_valid === 1'b1) begin
                if (n < 4163) early++;
                if (first < 0) begin first = n; got = rx_ax_m_data; end
            end
        end
        tests_run++; if (early != 0) begin tests_failed++; $display("FAIL prime_early_valid: got %0d expected 0", early); end
        tests_run++; if (first != 4163) begin tests_failed++; $display("FAIL prime_latency: got %0d expected 4163", first); end
        tests_run++; if (got !== 32'hFEDC1234) begin tests_failed++; $display("FAIL prime_data: got %h expected fedc1234", got); end
    endtask

    task automatic test_backpressure;
        int early = 0, hold_bad = 0;
        logic [7:0] ovf_mid = 8'h0;
        rx_ax_m_ready = 1'b0;
        do_reset(16'h1000, 16'h2000, 1'b1);
        for (int n = 1; n <= 12455; n++) begin
            @(negedge ax_clk);
            if (n < 4163 && rx_ax_m_valid === 1'b1) early++;
            if (n >= 4163 && (rx_ax_m_valid !== 1'b1 || rx_ax_m_data !== 32'h20001000)) hold_bad++;
            if (n == 10000) ovf_mid = rx_ovf_cnt;
        end
        tests_run++; if (early != 0) begin tests_failed++; $display("FAIL bp_early_valid: got %0d expected 0", early); end
        tests_run++; if (hold_bad != 0) begin tests_failed++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", hold_bad); end
        tests_run++; if (ovf_mid !== 8'd1) begin tests_failed++; $display("FAIL bp_ovf_mid: got %0d expected 1", ovf_mid); end
        tests_run++; if (rx_ovf_cnt !== 8'd2) begin tests_failed++; $display("FAIL bp_ovf: got %0d expected 2", rx_ovf_cnt); end
        rx_ax_m_ready = 1'b1;
        @(negedge ax_clk);
        tests_run++; if (rx_ax_m_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drain_valid: got %b expected 0", rx_ax_m_valid); end
        tests_run++; if (rx_ovf_cnt !== 8'd2) begin tests_failed++; $display("FAIL bp_ovf_after: got %0d expected 2", rx_ovf_cnt); end
    endtask

    task automatic test_back_to_back;
        rx_ax_m_ready = 1'b0;
        do_reset(16'h0111, 16'h0222, 1'b1);
        repeat (8258) @(negedge ax_clk);
        tests_run++; if (rx_ax_m_valid !== 1'b1 || rx_ax_m_data !== 32'h02220111) begin tests_failed++; $display("FAIL sim_before: got %b/%h expected 1/02220111", rx_ax_m_valid, rx_ax_m_data); end
        rx_ax_m_ready = 1'b1;
        @(negedge ax_clk);
        tests_run++; if (rx_ax_m_valid !== 1'b1) begin tests_failed++; $display("FAIL sim_valid: got %b expected 1", rx_ax_m_valid); end
        tests_run++; if (rx_ax_m_data !== 32'h02230112) begin tests_failed++; $display("FAIL sim_data: got %h expected 02230112", rx_ax_m_data); end
        tests_run++; if (rx_ovf_cnt !== 8'd0) begin tests_failed++; $display("FAIL sim_ovf: got %0d expected 0", rx_ovf_cnt); end
        @(negedge ax_clk);
        tests_run++; if (rx_ax_m_valid !== 1'b0) begin tests_failed++; $display("FAIL sim_drain: got %b expected 0", rx_ax_m_valid); end
    endtask

    task automatic test_midframe_reset;
        int first = -1, early = 0;
        logic [31:0] got = 32'h0;
        rx_ax_m_ready = 1'b0;
        do_reset(16'h0A00, 16'hF500, 1'b1);
        repeat (6700) @(negedge ax_clk);
        tests_run++; if (rx_ax_m_valid !== 1'b1 || rx_LRCIN !== 1'b1) begin tests_failed++; $display("FAIL mid_pre: got valid %b lrcin %b expected 1 1", rx_ax_m_valid, rx_LRCIN); end
        ax_rst = 1'b1;
        @(negedge ax_clk);
        tests_run++; if ({rx_Bclk, rx_LRCIN, rx_ax_m_valid} !== 3'b000) begin tests_failed++; $display("FAIL mid_rst_ctrl: got %b expected 000", {rx_Bclk, rx_LRCIN, rx_ax_m_valid}); end
        tests_run++; if (rx_ax_m_data !== 32'h0) begin tests_failed++; $display("FAIL mid_rst_data: got %h expected 00000000", rx_ax_m_data); end
        tests_run++; if (rx_ovf_cnt !== 8'h0) begin tests_failed++; $display("FAIL mid_rst_ovf: got %0d expected 0", rx_ovf_cnt); end
        ax_rst = 1'b0;
        for (int n = 1; n <= 4170; n++) begin
            @(negedge ax_clk);
            if (rx_ax_m_valid === 1'b1) begin
                if (n < 4163) early++;
                if (first < 0) begin first = n; got = rx_ax_m_data; end
            end
        end
        tests_run++; if (early != 0) begin tests_failed++; $display("FAIL mid_early_valid: got %0d expected 0", early); end
        tests_run++; if (first != 4163) begin tests_failed++; $display("FAIL mid_latency: got %0d expected 4163", first); end
        tests_run++; if (got !== 32'hF5020A02) begin tests_failed++; $display("FAIL mid_data: got %h expected f5020a02", got); end
    endtask

    task automatic test_saturation;
        while ((cyc - sat_rel) < 65542) @(negedge ax_clk);
        tests_run++; if ((cyc - sat_rel) != 65542) begin tests_failed++; $display("FAIL sat_sync: got %0d expected 65542", cyc - sat_rel); end
        tests_run++; if (sat_ovf !== 8'd254) begin tests_failed++; $display("FAIL sat_254: got %0d expected 254", sat_ovf); end
        @(negedge ax_clk);
        tests_run++; if (sat_ovf !== 8'd255) begin tests_failed++; $display("FAIL sat_255: got %0d expected 255", sat_ovf); end
        while ((cyc - sat_rel) < 77100) @(negedge ax_clk);
        tests_run++; if (sat_ovf !== 8'd255 || sat_valid !== 1'b1) begin tests_failed++; $display("FAIL sat_hold: got ovf %0d valid %b expected 255 1", sat_ovf, sat_valid); end
    endtask

    initial begin
        ax_rst = 1'b1;
        sat_rst = 1'b1;
        sat_ready = 1'b0;
        rx_ax_m_ready = 1'b1;
        tx_left = 16'h8001;
        tx_right = 16'h7FFE;
        auto_inc = 1'b0;
        test_reset;
        test_clocks;
        test_single_frame;
        test_priming;
        test_backpressure;
        test_back_to_back;
        test_midframe_reset;
        test_saturation;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
